// File: rtl/wb_trace_tx_if.sv
// Trace/stream bundle for the commit-trace transmitter.
//   trace_*   retirement event from MEM/WB (valid, reg_write, rd_addr, pc, rd_data)
//   tx_*      byte-wide valid/ready stream towards the host/debug port
// slave  : transmitter side (consumes trace, drives tx_data/tx_valid)
// master : pipeline + sink side (drives trace and tx_ready)
interface wb_trace_tx_if;
  logic        trace_valid;
  logic        trace_reg_write;
  logic [4:0]  trace_rd_addr;
  logic [31:0] trace_pc;
  logic [31:0] trace_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport slave (
    input  trace_valid, trace_reg_write, trace_rd_addr, trace_pc, trace_rd_data,
    input  tx_ready,
    output tx_data, tx_valid
  );

  modport master (
    output trace_valid, trace_reg_write, trace_rd_addr, trace_pc, trace_rd_data,
    output tx_ready,
    input  tx_data, tx_valid
  );
endinterface

// File: rtl/wb_trace_tx.sv
// Commit-trace transmitter: queues retired writeback events in a small FIFO and
// serialises each as a 10-byte record (HDR, {rw,00,rd}, pc LE, data LE).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus           wb_trace_tx_if.slave (trace input, tx byte stream)
//   fifo_count    records queued (excludes the one being transmitted)
//   overflow      sticky, a record was dropped since reset
//   drop_count    dropped records, saturating
//
// state | meaning
// IDLE  | nothing to send, waiting for a queued record
// LOAD  | head record captured into the shift register, bubble cycle
// SEND  | presenting byte idx, advancing on each handshake
module wb_trace_tx #(
  parameter int          DEPTH = 8,
  parameter int          XLEN  = 32,
  parameter logic [7:0]  HDR   = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  wb_trace_tx_if.slave           bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [15:0]            drop_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 6 + 2 * XLEN;
  localparam int SR_W  = 16 + 2 * XLEN;
  localparam logic [3:0] LAST_IDX = 4'd9;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t            state_q, state_d;
  logic [REC_W-1:0]  mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [SR_W-1:0]   sreg_q;
  logic [3:0]        idx_q;
  logic              empty, full, pop, hs, push_ok, drop;
  logic [REC_W-1:0]  rec_in, head;
  logic [SR_W-1:0]   sreg_load;
  logic [7:0]        tx_data_c;
  logic              tx_valid_c;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_count = wr_ptr - rd_ptr;

  assign rec_in  = {bus.trace_reg_write, bus.trace_rd_addr, bus.trace_pc, bus.trace_rd_data};
  assign head    = mem[rd_ptr[AW-1:0]];
  // Byte 0 sits in the low byte so transmission is a plain right shift.
  assign sreg_load = {head[XLEN-1:0], head[2*XLEN-1 -: XLEN],
                      head[REC_W-1], 2'b00, head[REC_W-2 -: 5], HDR};

  // A full FIFO still takes a push on the cycle its head is popped.
  assign push_ok = bus.trace_valid && (!full || pop);
  assign drop    = bus.trace_valid && !push_ok;

  assign bus.tx_data  = tx_data_c;
  assign bus.tx_valid = tx_valid_c;

  // The head is popped on the transition into LOAD rather than inside it, so
  // the slot frees on the B9 handshake edge and a push there is not dropped.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    hs         = 1'b0;
    tx_valid_c = 1'b0;
    tx_data_c  = 8'h00;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = SEND;
      SEND: begin
        tx_valid_c = 1'b1;
        tx_data_c  = sreg_q[7:0];
        if (bus.tx_ready) begin
          hs = 1'b1;
          if (idx_q == LAST_IDX) begin
            if (!empty) begin
              pop     = 1'b1;
              state_d = LOAD;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sreg_q     <= '0;
      idx_q      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state_q <= state_d;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        sreg_q <= sreg_load;
        idx_q  <= '0;
      end else if (hs) begin
        sreg_q <= {8'h00, sreg_q[SR_W-1:8]};
        idx_q  <= idx_q + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= rec_in;
  end

endmodule

// File: tb/tb_wb_trace_tx.sv
module tb_wb_trace_tx;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [15:0] drop_count;

  wb_trace_tx_if bus ();

  wb_trace_tx #(.DEPTH(DEPTH), .XLEN(32), .HDR(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  logic       stall_q = 1'b0;
  logic [7:0] held_q  = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Collects accepted bytes and checks that a stalled byte stays put.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_q) begin
        check("stall_valid", {31'd0, bus.tx_valid}, 32'd1);
        check("stall_data", {24'd0, bus.tx_data}, {24'd0, held_q});
      end
      if (bus.tx_valid && bus.tx_ready) rx_q.push_back(bus.tx_data);
      stall_q = bus.tx_valid && !bus.tx_ready;
      held_q  = bus.tx_data;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] data);
    bus.trace_valid     = 1'b1;
    bus.trace_reg_write = rw;
    bus.trace_rd_addr   = rd;
    bus.trace_pc        = pc;
    bus.trace_rd_data   = data;
  endtask

  task automatic expect_rec(input logic rw, input logic [4:0] rd, input logic [31:0] pc,
                            input logic [31:0] data);
    exp_q.push_back(8'hA5);
    exp_q.push_back({rw, 2'b00, rd});
    for (int i = 0; i < 4; i++) exp_q.push_back(pc[8*i +: 8]);
    for (int i = 0; i < 4; i++) exp_q.push_back(data[8*i +: 8]);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      step();
      c++;
    end
    check(tag, rx_q.size(), n);
  endtask

  task automatic compare_bytes(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) check($sformatf("%s_b%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
      else check($sformatf("%s_b%0d_missing", tag, i), 32'd0, 32'd1);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic rec_of(input int i, output logic rw, output logic [4:0] rd,
                        output logic [31:0] pc, output logic [31:0] data);
    rw   = i[0];
    rd   = i[4:0];
    pc   = 32'h0000_1000 + 32'(i) * 32'd4;
    data = 32'(i) * 32'h1111_1111 + 32'h0101_0000;
  endtask

  initial begin
    logic       rw;
    logic [4:0] rd;
    logic [31:0] pc, data;
    bit pushed;

    rst = 1'b1;
    bus.tx_ready        = 1'b0;
    bus.trace_valid     = 1'b0;
    bus.trace_reg_write = 1'b0;
    bus.trace_rd_addr   = '0;
    bus.trace_pc        = '0;
    bus.trace_rd_data   = '0;
    repeat (3) step();
    check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check("rst_fifo_count", {28'd0, fifo_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drop_count", {16'd0, drop_count}, 32'd0);
    rst = 1'b0;
    step();

    // 1: single record, sink always ready; B0 two edges after the push edge.
    bus.tx_ready = 1'b1;
    drive(1'b1, 5'd5, 32'h0000_0004, 32'hDEAD_BEEF);
    step();
    bus.trace_valid = 1'b0;
    check("t1_count_after_push", {28'd0, fifo_count}, 32'd1);
    check("t1_valid_e1", {31'd0, bus.tx_valid}, 32'd0);
    step();
    check("t1_valid_load", {31'd0, bus.tx_valid}, 32'd0);
    step();
    check("t1_valid_b0", {31'd0, bus.tx_valid}, 32'd1);
    check("t1_data_b0", {24'd0, bus.tx_data}, 32'h0000_00A5);
    wait_bytes("t1_len", 10, 40);
    exp_q = '{8'hA5, 8'h85, 8'h04, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    compare_bytes("t1");
    repeat (3) step();
    check("t1_idle_after", {31'd0, bus.tx_valid}, 32'd0);

    // 2: same record with a randomly stalling sink.
    drive(1'b1, 5'd5, 32'h0000_0004, 32'hDEAD_BEEF);
    step();
    bus.trace_valid = 1'b0;
    for (int c = 0; c < 200 && rx_q.size() < 10; c++) begin
      bus.tx_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.tx_ready = 1'b1;
    check("t2_len", rx_q.size(), 10);
    exp_q = '{8'hA5, 8'h85, 8'h04, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    compare_bytes("t2");
    repeat (3) step();

    // 3: blocked sink, DEPTH+1+3 pushes: DEPTH queued, one in flight, 3 dropped.
    bus.tx_ready = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      rec_of(i, rw, rd, pc, data);
      drive(rw, rd, pc, data);
      step();
    end
    bus.trace_valid = 1'b0;
    check("t3_fifo_count", {28'd0, fifo_count}, DEPTH);
    check("t3_drop_count", {16'd0, drop_count}, 32'd3);
    check("t3_overflow", {31'd0, overflow}, 32'd1);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      rec_of(i, rw, rd, pc, data);
      expect_rec(rw, rd, pc, data);
    end
    wait_bytes("t3_len", 10 * (DEPTH + 1), 300);
    repeat (5) step();
    check("t3_no_extra", rx_q.size(), 10 * (DEPTH + 1));
    compare_bytes("t3");

    // 4: FIFO full, push on the B9 handshake edge that pops the head.
    bus.tx_ready = 1'b0;
    for (int i = 20; i < 20 + DEPTH + 1; i++) begin
      rec_of(i, rw, rd, pc, data);
      drive(rw, rd, pc, data);
      expect_rec(rw, rd, pc, data);
      step();
    end
    bus.trace_valid = 1'b0;
    check("t4_full", {28'd0, fifo_count}, DEPTH);
    bus.tx_ready = 1'b1;
    pushed = 1'b0;
    for (int c = 0; c < 20 && !pushed; c++) begin
      if (rx_q.size() == 9) begin
        check("t4_b9_valid", {31'd0, bus.tx_valid}, 32'd1);
        drive(1'b1, 5'd31, 32'hCAFE_0010, 32'h0BAD_F00D);
        expect_rec(1'b1, 5'd31, 32'hCAFE_0010, 32'h0BAD_F00D);
        step();
        bus.trace_valid = 1'b0;
        pushed = 1'b1;
        check("t4_count_same", {28'd0, fifo_count}, DEPTH);
        check("t4_drop_same", {16'd0, drop_count}, 32'd3);
      end else begin
        step();
      end
    end
    check("t4_pushed", {31'd0, pushed}, 32'd1);
    wait_bytes("t4_len", 10 * (DEPTH + 2), 300);
    compare_bytes("t4");
    repeat (3) step();

    // 5: reset during B4 with 3 records queued.
    bus.tx_ready = 1'b0;
    for (int i = 40; i < 44; i++) begin
      rec_of(i, rw, rd, pc, data);
      drive(rw, rd, pc, data);
      step();
    end
    bus.trace_valid = 1'b0;
    check("t5_queued", {28'd0, fifo_count}, 32'd3);
    bus.tx_ready = 1'b1;
    for (int c = 0; c < 20 && rx_q.size() < 4; c++) step();
    check("t5_at_b4", {24'd0, bus.tx_data}, 32'h0000_0000 | {24'd0, 8'(32'h0000_1000 + 32'd40 * 32'd4 >> 16)});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("t5_count", {28'd0, fifo_count}, 32'd0);
    check("t5_overflow", {31'd0, overflow}, 32'd0);
    check("t5_drop", {16'd0, drop_count}, 32'd0);
    rx_q.delete();
    repeat (3) step();
    check("t5_quiet", rx_q.size(), 0);
    drive(1'b1, 5'd9, 32'h0000_2000, 32'h1234_5678);
    step();
    bus.trace_valid = 1'b0;
    exp_q = '{8'hA5, 8'h89, 8'h00, 8'h20, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    wait_bytes("t5_len", 10, 40);
    compare_bytes("t5");

    // 6: rd=0, rw=0 still emits a record with B1=00.
    drive(1'b0, 5'd0, 32'h0000_0008, 32'h0000_0000);
    step();
    bus.trace_valid = 1'b0;
    wait_bytes("t6_len", 10, 40);
    check("t6_b1", {24'd0, rx_q[1]}, 32'd0);
    exp_q = '{8'hA5, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    compare_bytes("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
